// File: rtl/regfile_mp.sv
// Multi-port integer register file with bypass, pending scoreboard and clear engine.
// Define REGFILE_MP_CONFLICT_CHECK_EN to enable the sticky wr_conflict flag and its assertion.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rd_pending,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  wr_conflict
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [AW-1:0]       cnt;
  logic                busy_q;
  logic [NREGS-1:0]    pend;
  logic [NREGS-1:0]    pend_nx;
  logic [DATA_W-1:0]   mem [NREGS];
  logic [AW-1:0]       wa [NWR];
  logic [DATA_W-1:0]   wd [NWR];
  logic [NWR-1:0]      wr_ok;

  assign clr_busy = busy_q;

  for (genvar i = 0; i < NWR; i++) begin : g_wport
    assign wa[i]    = waddr[i*AW +: AW];
    assign wd[i]    = wdata[i*DATA_W +: DATA_W];
    assign wr_ok[i] = wen[i] && !busy_q &&
                      !(ZERO_REG != 0 && wa[i] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NREGS - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Ascending port order: the last (highest) enabled port wins the NBA race.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i]) mem[wa[i]] <= wd[i];
      end
    end
  end

  // Allocation applied after write clears: the younger producer wins.
  always_comb begin
    pend_nx = pend;
    for (int i = 0; i < NWR; i++) begin
      if (wr_ok[i]) pend_nx[wa[i]] = 1'b0;
    end
    if (alloc_en) pend_nx[alloc_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else if (!busy_q) begin
      pend <= clr_req ? '0 : pend_nx;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rport
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[r*AW +: AW];

    always_comb begin
      rd = mem[ra];
      for (int i = 0; i < NWR; i++) begin
        if (wen[i] && wa[i] == ra) rd = wd[i];
      end
      if (busy_q || (ZERO_REG != 0 && ra == '0)) rd = '0;
    end

    assign rdata[r*DATA_W +: DATA_W] = rd;
    assign rd_pending[r] = !busy_q && pend[ra];
  end

`ifdef REGFILE_MP_CONFLICT_CHECK_EN
  logic conflict;
  logic conf_q;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_ok[i] && wr_ok[j] && wa[i] == wa[j]) conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conf_q <= 1'b0;
    else if (conflict) conf_q <= 1'b1;
  end

  assign wr_conflict = conf_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (!conflict)
      else $error("regfile_mp: same-address multi-write");
  end
`endif
`else
  assign wr_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a behavioural array/scoreboard model
// checked on every falling edge.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     wen;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]     rd_pending;
  logic           alloc_en;
  logic [AW-1:0]  alloc_addr;
  logic           clr_req;
  logic           clr_busy;
  logic           wr_conflict;

  int checks = 0;
  int failures = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rd_pending(rd_pending),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .clr_req(clr_req),
    .clr_busy(clr_busy), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_MP_CONFLICT_CHECK_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  // Behavioural model: contents, pending set, remaining clear cycles.
  logic [DW-1:0] m_mem [NR];
  bit            m_pend [NR];
  int            m_left;
  bit            m_conf;

  function automatic int wa_of(int p);
    return int'(waddr[p*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] wd_of(int p);
    return wdata[p*DW +: DW];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = NR;
      m_conf = 0;
      for (int k = 0; k < NR; k++) begin
        m_pend[k] = 0;
        m_mem[k] = '0;
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else begin
      if (wen == 2'b11 && wa_of(0) == wa_of(1) && wa_of(0) != 0)
        m_conf = 1;
      for (int p = 0; p < 2; p++) begin
        if (wen[p] && wa_of(p) != 0) begin
          m_mem[wa_of(p)] = wd_of(p);
          m_pend[wa_of(p)] = 0;
        end
      end
      if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1;
      if (clr_req) begin
        m_left = NR;
        for (int k = 0; k < NR; k++) begin
          m_pend[k] = 0;
          m_mem[k] = '0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(int ra);
    logic [DW-1:0] v;
    if (m_left > 0 || ra == 0) return '0;
    v = m_mem[ra];
    for (int p = 0; p < 2; p++)
      if (wen[p] && wa_of(p) == ra) v = wd_of(p);
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      int ra;
      ra = int'(raddr[r*AW +: AW]);
      chk($sformatf("model_rdata%0d", r), rdata[r*DW +: DW], exp_rd(ra));
      chk($sformatf("model_pend%0d", r), 64'(rd_pending[r]),
          64'((m_left == 0) && m_pend[ra]));
    end
    chk("model_busy", 64'(clr_busy), 64'(m_left > 0));
    chk("model_conf", 64'(wr_conflict), 64'(CONF_EN && m_conf));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    wen = '0;
    alloc_en = 0;
    clr_req = 0;
  endtask

  task automatic wr(int p, int a, logic [DW-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd_at(int r, int a);
    raddr[r*AW +: AW] = AW'(a);
  endtask

  task automatic count_busy(string name);
    int n;
    n = 0;
    while (clr_busy && n < 100) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'(NR));
  endtask

  initial begin
    rst = 1;
    wen = '0; waddr = '0; wdata = '0; raddr = '0;
    alloc_en = 0; alloc_addr = '0; clr_req = 0;
    repeat (3) tick();
    chk("reset_busy", 64'(clr_busy), 64'd1);
    chk("reset_conf", 64'(wr_conflict), 64'd0);
    rst = 0;
    count_busy("clear_len_reset");

    for (int a = 0; a < NR; a++) begin
      rd_at(0, a);
      rd_at(1, NR - 1 - a);
      #1;
      chk("cleared_p0", rdata[63:0], 64'd0);
      chk("cleared_p1", rdata[127:64], 64'd0);
      tick();
    end

    wr(0, 5, 64'hDEAD_BEEF);
    rd_at(0, 5);
    #1 chk("bypass_a5", rdata[63:0], 64'hDEAD_BEEF);
    tick();
    idle_in();
    #1 chk("array_a5", rdata[63:0], 64'hDEAD_BEEF);

    wr(0, 7, 64'h11);
    wr(1, 7, 64'h22);
    rd_at(0, 7);
    #1 chk("multi_bypass", rdata[63:0], 64'h22);
    tick();
    idle_in();
    #1 chk("multi_array", rdata[63:0], 64'h22);
    chk("conflict_flag", 64'(wr_conflict), 64'(CONF_EN));

    wr(0, 0, 64'hFFFF);
    rd_at(0, 0);
    #1 chk("zero_bypass", rdata[63:0], 64'd0);
    tick();
    idle_in();
    alloc_en = 1;
    alloc_addr = 5'd0;
    tick();
    idle_in();
    #1 chk("zero_array", rdata[63:0], 64'd0);
    chk("zero_pend", 64'(rd_pending[0]), 64'd0);

    alloc_en = 1;
    alloc_addr = 5'd9;
    rd_at(0, 9);
    rd_at(1, 9);
    tick();
    idle_in();
    wr(0, 9, 64'h99);
    #1 chk("pend_set", 64'(rd_pending[0]), 64'd1);
    chk("pend_samecyc", 64'(rd_pending[1]), 64'd1);
    tick();
    idle_in();
    #1 chk("pend_cleared", 64'(rd_pending[0]), 64'd0);
    chk("wb_a9", rdata[63:0], 64'h99);
    alloc_en = 1;
    alloc_addr = 5'd9;
    wr(1, 9, 64'h77);
    tick();
    idle_in();
    #1 chk("alloc_wins", 64'(rd_pending[0]), 64'd1);
    chk("alloc_wins_data", rdata[63:0], 64'h77);

    wr(0, 3, 64'h55);
    rd_at(0, 3);
    tick();
    idle_in();
    #1 chk("a3_written", rdata[63:0], 64'h55);
    clr_req = 1;
    tick();
    idle_in();
    #1 chk("clr_started", 64'(clr_busy), 64'd1);
    chk("clr_read0", rdata[63:0], 64'd0);
    repeat (10) tick();
    #2 rst = 1;
    tick();
    rst = 0;
    count_busy("clear_len_restart");
    rd_at(1, 9);
    #1 chk("a3_cleared", rdata[63:0], 64'd0);
    chk("a9_unpend", 64'(rd_pending[1]), 64'd0);
    chk("a9_cleared", rdata[127:64], 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the 2R1W 64-bit register file in the core.
- Adds configurable width, depth and read/write port counts, plus priority-resolved multi-write and per-port write-to-read bypass.
- Adds a pending-write scoreboard for issue logic and a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode/issue (reads, allocations) and writeback (writes).

Parameters:
DATA_W, 64, register width in bits
NREGS, 32, number of architectural registers (power of two, >=4)
NRD, 2, number of read ports
NWR, 2, number of write ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending
(local) AW = $clog2(NREGS)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wen  in  NWR  per-port write enable
waddr  in  NWR*AW  write addresses, port i at [i*AW +: AW]
wdata  in  NWR*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
raddr  in  NRD*AW  read addresses
rdata  out  NRD*DATA_W  read data, combinational
rd_pending  out  NRD  per read port: addressed register has an outstanding allocation
alloc_en  in  1  mark alloc_addr pending (destination issued)
alloc_addr  in  AW  register to mark pending
clr_req  in  1  request a full array clear
clr_busy  out  1  clear engine active; writes and allocations ignored
wr_conflict  out  1  sticky same-address multi-write flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous and active-high on rst.
- Reset (async assert):
  - FSM goes to CLEAR with counter 0 and clr_busy=1.
  - All pending bits clear to 0; wr_conflict clears to 0.
  - Array contents are undefined until the clear completes.
- FSM states:
  - CLEAR: each cycle writes 0 to register[counter] and increments counter. After counter==NREGS-1 is written, go to IDLE; clr_busy drops the following cycle. Total duration is NREGS cycles after rst deasserts.
  - IDLE: clr_req=1 at a posedge moves the FSM to CLEAR next cycle and clears all pending bits at that edge. clr_req is ignored while in CLEAR.
- Reads while clr_busy=1 return 0 and rd_pending=0.
- Read path, purely combinational, evaluated in this order:
  - ZERO_REG=1 and raddr==0 -> 0.
  - Otherwise, the highest-index write port with wen=1 and waddr==raddr supplies the data (bypass).
  - Otherwise, the array value.
- Write path, at posedge, when not clr_busy:
  - Every enabled port writes.
  - If several ports target the same address, the highest-index port wins.
  - Writes to register 0 are discarded when ZERO_REG=1.
- Scoreboard, at posedge, when not clr_busy:
  - alloc_en sets pending[alloc_addr].
  - Any enabled write to a register clears its pending bit.
  - Allocation and write to the same address in the same cycle -> alloc wins (bit set), since the new producer is younger.
  - Register 0 never pending when ZERO_REG=1.
- rd_pending[i] = pending[raddr_i], with no bypass: a write in the same cycle does not clear it until the next cycle.
- No read latency; write-to-array latency 1 cycle, hidden by bypass.

Optional Feature:
- Macro: REGFILE_MP_CONFLICT_CHECK_EN.
- Defined:
  - wr_conflict sets at the posedge where two or more enabled write ports share an address (excluding discarded writes to register 0), and stays set until rst.
  - A simulation-only assertion fires on the same condition.
- Undefined: wr_conflict is tied to 0, with no assertion and no extra logic.

Test Plan:
- Reset then idle -> clr_busy=1 for exactly NREGS (32) cycles after rst drops; afterwards every raddr returns 0.
- Write port0 addr 5 = 0xDEAD_BEEF, reading addr 5 on rdata0 in the same cycle -> rdata0=0xDEAD_BEEF combinationally; next cycle with wen=0 still 0xDEAD_BEEF.
- Ports 0 and 1 both write addr 7 (0x11, 0x22) -> same-cycle read gives 0x22, array holds 0x22, wr_conflict=1 next cycle with macro, 0 without.
- Write addr 0 = 0xFFFF with ZERO_REG=1 -> read addr 0 returns 0; alloc addr 0 -> rd_pending stays 0.
- alloc addr 9, then next cycle write addr 9 -> rd_pending=1 until the cycle after the write; alloc and write addr 9 in the same cycle -> pending stays 1.
- Pulse clr_req after writing addr 3 = 0x55, and assert rst mid-clear -> clear restarts from counter 0, clr_busy=1 for a fresh 32 cycles, addr 3 reads 0 afterwards.
